// File: rtl/hbc_prefetch.sv
// hbc_prefetch: linear read-prefetch engine in front of the HyperRAM
// controller's burst-read port.
//
// A transfer (base_addr, len_dw) is split into bursts of at most BURST_DW
// dwords. A burst is requested only when the local FIFO has room for all of
// it. Returned dwords are buffered and handed to the consumer over a
// valid/ready stream with a registered head word.
//
// Ports:
//   clk, reset                      clock, asynchronous active-high reset
//   start, base_addr, len_dw        transfer launch and parameters
//   abort                           cancel transfer and flush the FIFO
//   busy, done, err_ovf             status (err_ovf is sticky)
//   ext_rd_req/ack, ext_addr,
//   ext_burst_dw                    burst request handshake to the controller
//   ext_rdata, ext_rvalid           returned dwords
//   out_valid, out_ready, out_data  consumer stream
module hbc_prefetch #(
  parameter int FIFO_DEPTH = 64,
  parameter int BURST_DW   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] base_addr,
  input  logic [15:0] len_dw,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        err_ovf,
  output logic        ext_rd_req,
  output logic [31:0] ext_addr,
  output logic [7:0]  ext_burst_dw,
  input  logic        ext_rd_ack,
  input  logic [31:0] ext_rdata,
  input  logic        ext_rvalid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [23:0]   addr_q, addr_d;
  logic [15:0]   rem_q, rem_d;
  logic [8:0]    pend_q, pend_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_ovf_q, err_ovf_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_data_q, out_data_d;
  logic [31:0]   mem_q [FIFO_DEPTH];

  logic [8:0]    burst_n;
  logic [CW-1:0] free_space;
  logic [CW-1:0] count_left;
  logic          push;
  logic          pop;
  logic          unused_base_lsb;

  assign unused_base_lsb = ^base_addr[1:0];

  // Size of the next burst: whatever is left, capped at BURST_DW.
  assign burst_n    = (rem_q >= 16'(BURST_DW)) ? 9'(BURST_DW) : rem_q[8:0];
  assign free_space = CW'(FIFO_DEPTH) - count_q;

  // The request is only raised once the whole burst is guaranteed to fit,
  // which is what makes FIFO overflow impossible.
  assign ext_rd_req   = (state_q == S_REQ) && (32'(free_space) >= 32'(burst_n));
  assign ext_addr     = {8'h00, addr_q};
  assign ext_burst_dw = (state_q == S_REQ) ? 8'(burst_n - 9'd1) : 8'h00;

  assign push = (state_q == S_DATA) && ext_rvalid && !abort;
  assign pop  = out_valid_q && out_ready && !abort;

  // FIFO bookkeeping and registered head word
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    out_data_d = out_data_q;
    count_left = count_q - CW'(pop);
    if (abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_left + CW'(push);
      // With nothing left behind the head, the incoming word becomes the head
      // directly; otherwise the next stored word moves up.
      if (count_left == '0) begin
        if (push) out_data_d = ext_rdata;
      end else begin
        out_data_d = mem_q[rd_ptr_d];
      end
    end
    out_valid_d = (count_d != '0);
  end

  // Transfer sequencing
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    pend_d    = pend_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_ovf_d = err_ovf_q;
    if (abort) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            err_ovf_d = 1'b0;
            if (len_dw != 16'd0) begin
              addr_d  = {base_addr[23:2], 2'b00};
              rem_d   = len_dw;
              busy_d  = 1'b1;
              state_d = S_REQ;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        S_REQ: begin
          if (ext_rd_req && ext_rd_ack) begin
            pend_d  = burst_n;
            addr_d  = addr_q + (24'(burst_n) << 2);
            rem_d   = rem_q - 16'(burst_n);
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (ext_rvalid) begin
            pend_d = pend_q - 9'd1;
            if (pend_q == 9'd1) state_d = (rem_q != 16'd0) ? S_REQ : S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Looking at the post-pop count lets done follow the final pop by
          // exactly one cycle.
          if (count_d == '0) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // Any dword outside a burst window is stray (e.g. after an abort).
    if (ext_rvalid && (state_q != S_DATA)) err_ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      pend_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_ovf_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      pend_q      <= pend_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_ovf_q   <= err_ovf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // FIFO storage: data only, never reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ext_rdata;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err_ovf   = err_ovf_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_hbc_prefetch.sv
module tb_hbc_prefetch;

  localparam int DEPTH = 32;
  localparam int BDW   = 16;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [23:0] base_addr;
  logic [15:0] len_dw;
  logic        busy, done, err_ovf;
  logic        ext_rd_req;
  logic [31:0] ext_addr;
  logic [7:0]  ext_burst_dw;
  logic        ext_rd_ack, ext_rvalid;
  logic [31:0] ext_rdata;
  logic        out_valid, out_ready;
  logic [31:0] out_data;

  always #5 clk = ~clk;

  hbc_prefetch #(.FIFO_DEPTH(DEPTH), .BURST_DW(BDW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .len_dw(len_dw), .abort(abort), .busy(busy), .done(done),
    .err_ovf(err_ovf), .ext_rd_req(ext_rd_req), .ext_addr(ext_addr),
    .ext_burst_dw(ext_burst_dw), .ext_rd_ack(ext_rd_ack),
    .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [23:0] a);
    return {a[9:2] ^ 8'hA5, a};
  endfunction

  // Consumer: 0 = never ready, 1 = always ready, 2 = random, 3 = manual
  int   cons_mode = 1;
  logic cons_ready = 1'b0;
  logic man_ready  = 1'b0;
  assign out_ready = (cons_mode == 3) ? man_ready : cons_ready;

  initial begin
    forever begin
      @(posedge clk); #1;
      case (cons_mode)
        0:       cons_ready = 1'b0;
        1:       cons_ready = 1'b1;
        default: cons_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Memory responder: acks requests and returns one dword per address
  logic        resp_gaps = 1'b0;
  logic        resp_hold = 1'b0;
  logic [23:0] ret_q[$];

  initial begin
    ext_rd_ack = 1'b0;
    ext_rvalid = 1'b0;
    ext_rdata  = '0;
    forever begin
      @(posedge clk); #1;
      ext_rd_ack = 1'b0;
      ext_rvalid = 1'b0;
      if (!resp_hold) begin
        if (ret_q.size() > 0) begin
          if (!resp_gaps || $urandom_range(0, 2) != 0) begin
            ext_rvalid = 1'b1;
            ext_rdata  = data_of(ret_q.pop_front());
          end
        end else if (ext_rd_req && (!resp_gaps || $urandom_range(0, 2) == 0)) begin
          ext_rd_ack = 1'b1;
          for (int i = 0; i <= int'(ext_burst_dw); i++)
            ret_q.push_back(ext_addr[23:0] + 24'(4 * i));
        end
      end
    end
  end

  // Monitor
  int          cyc = 0;
  logic [31:0] got_q[$];
  logic [23:0] raddr_q[$];
  logic [7:0]  rbdw_q[$];
  int          pops_at_req[$];
  int          pops = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          last_pop_cyc = 0;
  logic        busy_at_done = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (ext_rd_req && ext_rd_ack) begin
      raddr_q.push_back(ext_addr[23:0]);
      rbdw_q.push_back(ext_burst_dw);
      pops_at_req.push_back(pops);
    end
    if (out_valid && out_ready) begin
      got_q.push_back(out_data);
      pops++;
      last_pop_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
  end

  // Reference model: expected requests and data of a transfer
  logic [31:0] exp_data[$];
  logic [23:0] exp_raddr[$];
  logic [7:0]  exp_rbdw[$];

  task automatic build_model(input logic [23:0] b, input logic [15:0] l);
    logic [23:0] a;
    int rem, n;
    exp_data.delete(); exp_raddr.delete(); exp_rbdw.delete();
    a = {b[23:2], 2'b00};
    for (int i = 0; i < int'(l); i++) exp_data.push_back(data_of(a + 24'(4 * i)));
    rem = int'(l);
    while (rem > 0) begin
      n = (rem > BDW) ? BDW : rem;
      exp_raddr.push_back(a);
      exp_rbdw.push_back(8'(n - 1));
      a   = a + 24'(4 * n);
      rem = rem - n;
    end
  endtask

  task automatic start_xfer(input string tag, input logic [23:0] b, input logic [15:0] l);
    build_model(b, l);
    @(posedge clk); #1;
    got_q.delete(); raddr_q.delete(); rbdw_q.delete(); pops_at_req.delete();
    pops = 0; done_cnt = 0;
    base_addr = b; len_dw = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check($sformatf("%s_busy_after_start", tag), longint'(busy), 1);
    check($sformatf("%s_err_clear", tag), longint'(err_ovf), 0);
    check($sformatf("%s_req_rise", tag), longint'(ext_rd_req), 1);
    check($sformatf("%s_req_addr", tag), longint'(ext_addr), longint'(exp_raddr[0]));
    check($sformatf("%s_req_bdw", tag), longint'(ext_burst_dw), longint'(exp_rbdw[0]));
  endtask

  task automatic finish_xfer(input string tag);
    int t, mism;
    t = 0;
    while (done_cnt == 0 && t < 4000) begin
      @(posedge clk);
      t++;
    end
    check($sformatf("%s_done_seen", tag), longint'(done_cnt != 0), 1);
    repeat (3) @(posedge clk);
    check($sformatf("%s_words", tag), longint'(got_q.size()), longint'(exp_data.size()));
    mism = 0;
    for (int i = 0; i < got_q.size() && i < exp_data.size(); i++)
      if (got_q[i] !== exp_data[i]) mism++;
    check($sformatf("%s_data_order", tag), longint'(mism), 0);
    check($sformatf("%s_req_count", tag), longint'(raddr_q.size()), longint'(exp_raddr.size()));
    mism = 0;
    for (int i = 0; i < raddr_q.size() && i < exp_raddr.size(); i++)
      if (raddr_q[i] !== exp_raddr[i] || rbdw_q[i] !== exp_rbdw[i]) mism++;
    check($sformatf("%s_req_list", tag), longint'(mism), 0);
    check($sformatf("%s_done_pulses", tag), longint'(done_cnt), 1);
    check($sformatf("%s_done_after_pop", tag), longint'(done_cyc), longint'(last_pop_cyc + 1));
    check($sformatf("%s_busy_at_done", tag), longint'(busy_at_done), 0);
    check($sformatf("%s_err_ovf", tag), longint'(err_ovf), 0);
    check($sformatf("%s_out_valid_idle", tag), longint'(out_valid), 0);
  endtask

  typedef struct {
    logic [23:0] base;
    logic [15:0] len;
    int          nreq;
    logic [7:0]  last_bdw;
    logic [23:0] last_addr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int k, t;
    tbl[0] = '{24'h000100, 16'd16, 1, 8'd15, 24'h000100};
    tbl[1] = '{24'h000100, 16'd37, 3, 8'd4,  24'h000180};
    tbl[2] = '{24'hFFFFC0, 16'd32, 2, 8'd15, 24'h000000};
    tbl[3] = '{24'h000203, 16'd1,  1, 8'd0,  24'h000200};
    tbl[4] = '{24'h0000F0, 16'd33, 3, 8'd0,  24'h000170};
    tbl[5] = '{24'h000010, 16'd20, 2, 8'd3,  24'h000050};

    reset = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; len_dw = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_err_ovf", longint'(err_ovf), 0);
    check("rst_req", longint'(ext_rd_req), 0);
    check("rst_addr", longint'(ext_addr), 0);
    check("rst_bdw", longint'(ext_burst_dw), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Zero length: done next cycle, never busy, no request
    @(posedge clk); #1;
    done_cnt = 0; raddr_q.delete();
    len_dw = 16'd0; base_addr = 24'h000800; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("zero_done", longint'(done), 1);
    check("zero_busy", longint'(busy), 0);
    check("zero_req", longint'(ext_rd_req), 0);
    @(negedge clk);
    check("zero_done_single", longint'(done), 0);
    repeat (4) @(negedge clk);
    check("zero_no_request", longint'(raddr_q.size()), 0);

    // Table of directed transfers
    cons_mode = 1; resp_gaps = 1'b0;
    for (int v = 0; v < 6; v++) begin
      start_xfer($sformatf("tbl%0d", v), tbl[v].base, tbl[v].len);
      finish_xfer($sformatf("tbl%0d", v));
      check($sformatf("tbl%0d_nreq", v), longint'(raddr_q.size()), longint'(tbl[v].nreq));
      if (raddr_q.size() > 0) begin
        check($sformatf("tbl%0d_last_bdw", v), longint'(rbdw_q[rbdw_q.size()-1]), longint'(tbl[v].last_bdw));
        check($sformatf("tbl%0d_last_addr", v), longint'(raddr_q[raddr_q.size()-1]), longint'(tbl[v].last_addr));
      end
    end

    // Backpressure: consumer stalled, only two bursts fit
    cons_mode = 0;
    start_xfer("bp", 24'h002000, 16'd64);
    repeat (80) @(negedge clk);
    check("bp_two_bursts", longint'(raddr_q.size()), 2);
    check("bp_req_held_low", longint'(ext_rd_req), 0);
    check("bp_out_valid", longint'(out_valid), 1);
    cons_mode = 1;
    t = 0;
    while (raddr_q.size() < 3 && t < 500) begin
      @(posedge clk);
      t++;
    end
    check("bp_third_req", longint'(raddr_q.size() >= 3), 1);
    if (pops_at_req.size() >= 3) check("bp_release_pops", longint'(pops_at_req[2]), 16);
    finish_xfer("bp");

    // Simultaneous push and pop at DEPTH-1, plus a start while busy
    cons_mode = 3; man_ready = 1'b0;
    start_xfer("simul", 24'h003000, 16'd48);
    k = 0; t = 0;
    while (k < 32 && t < 500) begin
      @(negedge clk);
      t++;
      if (ext_rvalid) k++;
    end
    check("simul_reached", longint'(k), 32);
    man_ready = 1'b1;
    @(negedge clk);
    man_ready = 1'b0;
    check("simul_req_low", longint'(ext_rd_req), 0);
    base_addr = 24'hABCDEC; len_dw = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("simul_start_ignored_busy", longint'(busy), 1);
    for (int i = 1; i <= 15; i++) begin
      man_ready = 1'b1;
      @(negedge clk);
      man_ready = 1'b0;
      check($sformatf("simul_req_after_pop%0d", i), longint'(ext_rd_req), longint'(i == 15));
    end
    cons_mode = 1;
    finish_xfer("simul");

    // Abort with 5 dwords still pending
    cons_mode = 0;
    start_xfer("abort", 24'h005000, 16'd16);
    k = 0; t = 0;
    while (k < 11 && t < 200) begin
      @(negedge clk);
      t++;
      if (ext_rvalid) k++;
    end
    check("abort_reached", longint'(k), 11);
    resp_hold = 1'b1;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    resp_hold = 1'b0;
    check("abort_busy", longint'(busy), 0);
    check("abort_out_valid", longint'(out_valid), 0);
    check("abort_req", longint'(ext_rd_req), 0);
    check("abort_no_done", longint'(done), 0);
    k = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ext_rvalid) k++;
    end
    check("abort_stray_words", longint'(k), 5);
    check("abort_err_ovf", longint'(err_ovf), 1);
    check("abort_fifo_empty", longint'(out_valid), 0);
    check("abort_done_count", longint'(done_cnt), 0);
    cons_mode = 1;
    start_xfer("restart", 24'h006000, 16'd4);
    finish_xfer("restart");

    // Randomized transfers against the model
    cons_mode = 2; resp_gaps = 1'b1;
    for (int r = 0; r < 25; r++) begin
      start_xfer($sformatf("rand%0d", r), 24'($urandom), 16'($urandom_range(1, 90)));
      finish_xfer($sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
